// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the two requesters (instruction refill, CPU data),
// the arbiter, and the four byte-lane SRAM cells.
//   slave  : arbiter view (requests and cell_dout in; grants, read data,
//            cell controls and busy out)
//   master : requester/cell-side view (the opposite directions)
interface sram_port_arbiter_if #(
    parameter int unsigned AW = 9
) ();
    // instruction refill port
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    // data load/store port
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    // shared SRAM cell port, byte k <-> cell k
    logic [AW-1:0] cell_addr;
    logic [31:0]   cell_din;
    logic [3:0]    cell_wen;
    logic [3:0]    cell_sense_en;
    logic [31:0]   cell_dout;

    logic busy;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  cell_dout,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output cell_addr, cell_din, cell_wen, cell_sense_en,
        output busy
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output cell_dout,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  cell_addr, cell_din, cell_wen, cell_sense_en,
        input  busy
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter and sequencer sharing one four-lane SRAM port between
// the instruction refill path and the CPU data load/store path.
// Ports:
//   clk    : single clock, rising edge
//   rst    : asynchronous active-high reset
//   bus_io : sram_port_arbiter_if.slave carrying both request ports, the
//            per-lane cell controls/data and busy
// Transaction flow: IDLE -> ISSUE -> CAPTURE -> RESP for reads,
// IDLE -> ISSUE for stores. All outputs come straight from registers.
module sram_port_arbiter #(
    parameter int unsigned AW = 9
) (
    input  logic               clk,
    input  logic               rst,
    sram_port_arbiter_if.slave bus_io
);
    localparam int unsigned DW    = 32;
    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESP
    } state_e;

    state_e           state_q;
    logic             last_data_q;   // 1: data port won the previous grant
    logic             win_data_q;    // owner of the transaction in flight
    logic             we_q;
    logic [AW-1:0]    word_q;
    logic [DW-1:0]    wdata_q;

    logic             i_gnt_q;
    logic             d_gnt_q;
    logic             i_rvalid_q;
    logic             d_rvalid_q;
    logic [DW-1:0]    i_rdata_q;
    logic [DW-1:0]    d_rdata_q;
    logic [LANES-1:0] wen_q;
    logic [LANES-1:0] sense_q;
    logic             busy_q;

    logic             grant_data_c;
    logic             any_req_c;

    // On a tie the port that did not win last time gets the grant.
    assign any_req_c    = bus_io.i_req | bus_io.d_req;
    assign grant_data_c = bus_io.d_req & (~bus_io.i_req | ~last_data_q);

    // Sequencer: latches the winner in IDLE and walks the access through
    // the SRAM; gnt, wen and sense are set on the edge entering ISSUE so
    // they are high exactly for the ISSUE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_data_q <= 1'b0;
            win_data_q  <= 1'b0;
            we_q        <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            i_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            wen_q       <= '0;
            sense_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            wen_q      <= '0;
            sense_q    <= '0;

            case (state_q)
                ST_IDLE: begin
                    if (any_req_c) begin
                        win_data_q <= grant_data_c;
                        we_q       <= grant_data_c & bus_io.d_we;
                        wdata_q    <= bus_io.d_wdata;
                        word_q     <= grant_data_c ? bus_io.d_addr[AW+1:2]
                                                   : bus_io.i_addr[AW+1:2];
                        i_gnt_q    <= ~grant_data_c;
                        d_gnt_q    <= grant_data_c;
                        // Loads and refills always read the full word.
                        if (grant_data_c && bus_io.d_we) begin
                            wen_q <= bus_io.d_be;
                        end else begin
                            sense_q <= {LANES{1'b1}};
                        end
                        busy_q  <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    last_data_q <= win_data_q;
                    if (we_q) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_CAPTURE;
                    end
                end

                // Cell output is valid the cycle after sense.
                ST_CAPTURE: begin
                    if (win_data_q) begin
                        d_rdata_q  <= bus_io.cell_dout;
                        d_rvalid_q <= 1'b1;
                    end else begin
                        i_rdata_q  <= bus_io.cell_dout;
                        i_rvalid_q <= 1'b1;
                    end
                    state_q <= ST_RESP;
                end

                ST_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_io.i_gnt         = i_gnt_q;
    assign bus_io.d_gnt         = d_gnt_q;
    assign bus_io.i_rvalid      = i_rvalid_q;
    assign bus_io.d_rvalid      = d_rvalid_q;
    assign bus_io.i_rdata       = i_rdata_q;
    assign bus_io.d_rdata       = d_rdata_q;
    assign bus_io.cell_addr     = word_q;
    assign bus_io.cell_din      = wdata_q;
    assign bus_io.cell_wen      = wen_q;
    assign bus_io.cell_sense_en = sense_q;
    assign bus_io.busy          = busy_q;

    // High address bits alias by design and byte offsets are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus_io.i_addr[31:AW+2], bus_io.i_addr[1:0],
                                bus_io.d_addr[31:AW+2], bus_io.d_addr[1:0]};
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: a table of directed data-port
// transactions, hand-written corner sequences (request drop, reset mid-read,
// contention) and a randomized run against a transaction-level model.
module tb_sram_port_arbiter;
    localparam int unsigned AW    = 9;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.AW(AW)) bus ();
    sram_port_arbiter #(.AW(AW)) dut (.clk(clk), .rst(rst), .bus_io(bus));

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] pat(input int i);
        return 32'h13579BDF ^ (32'(i) * 32'h01000193);
    endfunction

    // Four byte-lane SRAM cells; mem_mode loads a known image.
    logic [31:0] sram [DEPTH];
    int mem_mode = 0;
    always @(posedge clk) begin
        if (mem_mode == 1) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= (i == 5) ? 32'hDEADBEEF : 32'h0;
        end else if (mem_mode == 2) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= pat(i);
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bus.cell_wen[k]) sram[bus.cell_addr][8*k +: 8] <= bus.cell_din[8*k +: 8];
                if (bus.cell_sense_en[k]) bus.cell_dout[8*k +: 8] <= sram[bus.cell_addr][8*k +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          we;
        logic [3:0]    be;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [AW-1:0] word;
        logic [31:0]   rdata;
    } vec_t;

    vec_t vecs [12];

    // One data-port transaction from an idle arbiter with exact latencies.
    task automatic d_txn(input vec_t v);
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = v.we; bus.d_be = v.be;
        bus.d_addr = v.addr; bus.d_wdata = v.wdata;
        @(negedge clk);
        chk("d_gnt_issue", 32'(bus.d_gnt), 1);
        chk("i_gnt_issue", 32'(bus.i_gnt), 0);
        chk("cell_addr", 32'(bus.cell_addr), 32'(v.word));
        chk("busy_issue", 32'(bus.busy), 1);
        if (v.we) begin
            chk("cell_wen", 32'(bus.cell_wen), 32'(v.be));
            chk("sense_on_store", 32'(bus.cell_sense_en), 0);
            chk("cell_din", bus.cell_din, v.wdata);
        end else begin
            chk("sense_on_load", 32'(bus.cell_sense_en), 32'hF);
            chk("wen_on_load", 32'(bus.cell_wen), 0);
        end
        bus.d_req = 1'b0;
        @(negedge clk);
        if (v.we) begin
            chk("busy_after_store", 32'(bus.busy), 0);
            chk("rvalid_store", 32'(bus.d_rvalid), 0);
            chk("wen_after_issue", 32'(bus.cell_wen), 0);
        end else begin
            chk("rvalid_capture", 32'(bus.d_rvalid), 0);
            chk("busy_capture", 32'(bus.busy), 1);
            chk("sense_capture", 32'(bus.cell_sense_en), 0);
            @(negedge clk);
            chk("d_rvalid_resp", 32'(bus.d_rvalid), 1);
            chk("d_rdata_resp", bus.d_rdata, v.rdata);
            chk("busy_resp", 32'(bus.busy), 1);
            @(negedge clk);
            chk("rvalid_idle", 32'(bus.d_rvalid), 0);
            chk("busy_idle", 32'(bus.busy), 0);
            chk("d_rdata_hold", bus.d_rdata, v.rdata);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_gnt"}, 32'({bus.i_gnt, bus.d_gnt}), 0);
        chk({tag, "_rvalid"}, 32'({bus.i_rvalid, bus.d_rvalid}), 0);
        chk({tag, "_wen"}, 32'(bus.cell_wen), 0);
        chk({tag, "_sense"}, 32'(bus.cell_sense_en), 0);
        chk({tag, "_i_rdata"}, bus.i_rdata, 0);
        chk({tag, "_d_rdata"}, bus.d_rdata, 0);
    endtask

    // Randomized run state and reference model.
    logic [31:0]   ref_mem [DEPTH];
    int            cyc, busy_end, gnt_cyc, rv_cyc, last_port, win;
    logic [AW-1:0] exp_word;
    logic [3:0]    exp_wen, exp_sense;
    logic [31:0]   exp_din, rv_data, exp_i_rdata, exp_d_rdata;
    bit            i_pend, d_pend;

    function automatic logic [31:0] rnd_addr();
        return ($urandom & 32'hFFFF_F800) | (32'($urandom_range(0, 15)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        int ngnt;
        int gport [4];
        int gat [4];
        bit eg_i, eg_d, erv_i, erv_d;

        vecs[0]  = '{1'b0, 4'h0, 32'h0000_0014, 32'h0,         AW'(5),   32'hDEADBEEF};
        vecs[1]  = '{1'b1, 4'h4, 32'h0000_0014, 32'h00AA_0000, AW'(5),   32'h0};
        vecs[2]  = '{1'b0, 4'h0, 32'h0000_0014, 32'h0,         AW'(5),   32'hDEAABEEF};
        vecs[3]  = '{1'b0, 4'h0, 32'h0001_0814, 32'h0,         AW'(5),   32'hDEAABEEF};
        vecs[4]  = '{1'b1, 4'h0, 32'h0000_0014, 32'hFFFF_FFFF, AW'(5),   32'h0};
        vecs[5]  = '{1'b0, 4'hF, 32'h0000_0014, 32'h0,         AW'(5),   32'hDEAABEEF};
        vecs[6]  = '{1'b1, 4'hF, 32'h0000_0017, 32'h1234_5678, AW'(5),   32'h0};
        vecs[7]  = '{1'b0, 4'h0, 32'h0000_0016, 32'h0,         AW'(5),   32'h12345678};
        vecs[8]  = '{1'b1, 4'h3, 32'h0000_07FC, 32'hFFFF_CAFE, AW'(511), 32'h0};
        vecs[9]  = '{1'b0, 4'h0, 32'h0000_07FC, 32'h0,         AW'(511), 32'h0000CAFE};
        vecs[10] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         AW'(0),   32'h0};
        vecs[11] = '{1'b0, 4'h0, 32'h0000_0014, 32'h0,         AW'(5),   32'h12345678};

        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
        mem_mode = 1;
        repeat (2) @(negedge clk);
        mem_mode = 0;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Directed table on the data port.
        foreach (vecs[n]) d_txn(vecs[n]);

        // Refill request pulsed for one IDLE cycle still completes.
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_07FC;
        @(negedge clk);
        bus.i_req = 1'b0;
        chk("drop_i_gnt", 32'(bus.i_gnt), 1);
        chk("drop_d_gnt", 32'(bus.d_gnt), 0);
        chk("drop_cell_addr", 32'(bus.cell_addr), 511);
        @(negedge clk);
        chk("drop_rvalid_early", 32'(bus.i_rvalid), 0);
        @(negedge clk);
        chk("drop_i_rvalid", 32'(bus.i_rvalid), 1);
        chk("drop_i_rdata", bus.i_rdata, 32'h0000CAFE);
        chk("drop_d_rvalid", 32'(bus.d_rvalid), 0);
        @(negedge clk);
        chk("drop_busy_end", 32'(bus.busy), 0);

        // Reset asserted during CAPTURE aborts the load.
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h14;
        @(negedge clk);
        chk("rst_mid_gnt", 32'(bus.d_gnt), 1);
        bus.d_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_mid_no_rvalid", 32'({bus.i_rvalid, bus.d_rvalid}), 0);
            chk("rst_mid_idle", 32'(bus.busy), 0);
        end
        d_txn(vecs[11]);

        // Contention: both ports held with reads from a fresh reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h7FC;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h14;
        ngnt = 0;
        for (int c = 1; c <= 40 && ngnt < 4; c++) begin
            @(negedge clk);
            chk("cont_gnt_excl", 32'(bus.i_gnt & bus.d_gnt), 0);
            chk("cont_rvalid_excl", 32'(bus.i_rvalid & bus.d_rvalid), 0);
            if (bus.i_gnt || bus.d_gnt) begin
                gport[ngnt] = bus.d_gnt ? 1 : 0;
                gat[ngnt] = c;
                ngnt++;
            end
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        chk("cont_grant_count", 32'(ngnt), 4);
        for (int g = 0; g < ngnt; g++) begin
            chk("cont_order", 32'(gport[g]), 32'((g % 2 == 0) ? 1 : 0));
            if (g > 0) chk("cont_spacing", 32'(gat[g] - gat[g-1]), 4);
        end

        // Randomized traffic against the transaction-level model.
        @(negedge clk);
        rst = 1'b1;
        mem_mode = 2;
        @(negedge clk);
        mem_mode = 0;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
        cyc = 0; busy_end = -1; gnt_cyc = -1; rv_cyc = -1; last_port = 0; win = 0;
        exp_i_rdata = '0; exp_d_rdata = '0; rv_data = '0;
        exp_word = '0; exp_wen = '0; exp_sense = '0; exp_din = '0;
        i_pend = 1'b0; d_pend = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            cyc++;
            eg_i  = (cyc == gnt_cyc) && (win == 0);
            eg_d  = (cyc == gnt_cyc) && (win == 1);
            erv_i = (cyc == rv_cyc) && (win == 0);
            erv_d = (cyc == rv_cyc) && (win == 1);
            if (erv_i) exp_i_rdata = rv_data;
            if (erv_d) exp_d_rdata = rv_data;
            chk("rnd_i_gnt", 32'(bus.i_gnt), 32'(eg_i));
            chk("rnd_d_gnt", 32'(bus.d_gnt), 32'(eg_d));
            chk("rnd_i_rvalid", 32'(bus.i_rvalid), 32'(erv_i));
            chk("rnd_d_rvalid", 32'(bus.d_rvalid), 32'(erv_d));
            chk("rnd_i_rdata", bus.i_rdata, exp_i_rdata);
            chk("rnd_d_rdata", bus.d_rdata, exp_d_rdata);
            chk("rnd_busy", 32'(bus.busy), 32'(cyc >= gnt_cyc && cyc <= busy_end));
            if (cyc == gnt_cyc) begin
                chk("rnd_cell_addr", 32'(bus.cell_addr), 32'(exp_word));
                chk("rnd_cell_wen", 32'(bus.cell_wen), 32'(exp_wen));
                chk("rnd_cell_sense", 32'(bus.cell_sense_en), 32'(exp_sense));
                if (exp_sense == 4'h0) chk("rnd_cell_din", bus.cell_din, exp_din);
            end else begin
                chk("rnd_ctrl_idle", 32'({bus.cell_wen, bus.cell_sense_en}), 0);
            end

            // Requesters hold until granted, then may re-request at once.
            if (bus.i_gnt) i_pend = 1'b0;
            if (bus.d_gnt) d_pend = 1'b0;
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1'b1;
                bus.i_addr = rnd_addr();
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1;
                bus.d_addr = rnd_addr();
                bus.d_we = 1'($urandom_range(0, 1));
                bus.d_be = 4'($urandom_range(0, 15));
                bus.d_wdata = $urandom;
            end
            bus.i_req = i_pend;
            bus.d_req = d_pend;

            // Predict the grant that follows this cycle's sample, if idle.
            if (cyc > busy_end && (bus.i_req || bus.d_req)) begin
                if (bus.i_req && bus.d_req) win = 1 - last_port;
                else win = bus.d_req ? 1 : 0;
                last_port = win;
                gnt_cyc = cyc + 1;
                exp_word = AW'(((win == 1 ? bus.d_addr : bus.i_addr) >> 2) % DEPTH);
                if (win == 1 && bus.d_we) begin
                    exp_wen = bus.d_be; exp_sense = 4'h0; exp_din = bus.d_wdata;
                    for (int k = 0; k < 4; k++)
                        if (bus.d_be[k]) ref_mem[exp_word][8*k +: 8] = bus.d_wdata[8*k +: 8];
                    busy_end = cyc + 1;
                    rv_cyc = -1;
                end else begin
                    exp_wen = 4'h0; exp_sense = 4'hF;
                    rv_data = ref_mem[exp_word];
                    rv_cyc = cyc + 3;
                    busy_end = cyc + 3;
                end
            end
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
